// File: rtl/wfg_drive_pat_pkg.sv
// Shared types for the waveform pattern driver: FSM states and per-channel mode encodings.
package wfg_drive_pat_pkg;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_RUNNING  = 2'd2
  } state_e;

  localparam int MODE_W = 2;
  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t MODE_LOW    = 2'd0;
  localparam mode_t MODE_HIGH   = 2'd1;
  localparam mode_t MODE_DATA   = 2'd2;
  localparam mode_t MODE_TOGGLE = 2'd3;

endpackage

// File: rtl/wfg_drive_pat_channel.sv
// One pattern output: toggle state plus the registered mode/window/idle output mux.
module wfg_drive_pat_channel
  import wfg_drive_pat_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  flush_i,
  input  logic  sync_i,
  input  logic  subcycle_i,
  input  mode_t mode_i,
  input  logic  data_i,
  input  logic  drive_i,
  input  logic  run_win_i,
  input  logic  idle_i,
  output logic  pat_o
);

  logic toggle_q, toggle_d;
  logic pat_q, pat_d;
  logic mode_val;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    toggle_d = toggle_q;
    if (flush_i || sync_i) begin
      toggle_d = 1'b0;
    end else if (subcycle_i) begin
      toggle_d = ~toggle_q;
    end

    unique case (mode_i)
      MODE_LOW:    mode_val = 1'b0;
      MODE_HIGH:   mode_val = 1'b1;
      MODE_DATA:   mode_val = data_i;
      MODE_TOGGLE: mode_val = toggle_d;
      default:     mode_val = 1'b0;
    endcase

    pat_d = 1'b0;
    if (drive_i) begin
      pat_d = run_win_i ? mode_val : idle_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      toggle_q <= 1'b0;
      pat_q    <= 1'b0;
    end else begin
      toggle_q <= toggle_d;
      pat_q    <= pat_d;
    end
  end

  assign pat_o = pat_q;

endmodule

// File: rtl/wfg_drive_pat.sv
// Pattern driver: FSM, 1-entry stream prefetch buffer, subcycle window and status.
// Define WFG_DRIVE_PAT_STATUS_EN to add the saturating underflow_cnt_o counter.
module wfg_drive_pat
  import wfg_drive_pat_pkg::*;
#(
  parameter int CHANNELS        = 8,
  parameter int AXIS_DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en_i,
  input  logic                         wfg_pat_sync_i,
  input  logic                         wfg_pat_subcycle_i,
  input  logic                         wfg_pat_start_i,
  input  logic [7:0]                   wfg_pat_subcycle_cnt_i,
  input  logic [AXIS_DATA_WIDTH-1:0]   wfg_axis_tdata_i,
  input  logic                         wfg_axis_tvalid_i,
  output logic                         wfg_axis_tready_o,
  input  logic [MODE_W*CHANNELS-1:0]   cfg_mode_i,
  input  logic [7:0]                   cfg_begin_i,
  input  logic [7:0]                   cfg_end_i,
  input  logic [CHANNELS-1:0]          cfg_idle_i,
  output logic [CHANNELS-1:0]          pat_o,
  output logic                         active_o,
  output logic                         underflow_o
`ifdef WFG_DRIVE_PAT_STATUS_EN
  ,
  output logic [15:0]                  underflow_cnt_o
`endif
);

  state_e              state_q, state_d;
  logic [CHANNELS-1:0] buf_q, buf_d;
  logic [CHANNELS-1:0] word_q, word_d;
  logic                buf_full_q, buf_full_d;
  logic                underflow_q, underflow_d;
  logic                active_q;
  logic                sync_live, underflow_evt, accept, in_win, run_win, drive;
  logic                unused_tdata;

  // Stream bits above CHANNELS-1 carry no pattern information.
  assign unused_tdata = ^wfg_axis_tdata_i;

  assign wfg_axis_tready_o = (state_q != ST_DISABLED) && !buf_full_q;
  assign accept            = wfg_axis_tvalid_i && wfg_axis_tready_o;
  assign sync_live         = en_i && wfg_pat_sync_i && (state_q != ST_DISABLED);
  assign underflow_evt     = sync_live && !buf_full_q;

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    word_d      = word_q;
    underflow_d = underflow_q;

    if (!en_i) begin
      state_d     = ST_DISABLED;
      buf_d       = '0;
      buf_full_d  = 1'b0;
      word_d      = '0;
      underflow_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_DISABLED: if (wfg_pat_start_i) state_d = ST_ARMED;
        ST_ARMED:    if (wfg_pat_sync_i)  state_d = ST_RUNNING;
        ST_RUNNING:  state_d = ST_RUNNING;
        default:     state_d = ST_DISABLED;
      endcase

      // accept only happens with the buffer empty, so it never collides with the sync hand-off.
      if (accept) begin
        buf_d      = wfg_axis_tdata_i[CHANNELS-1:0];
        buf_full_d = 1'b1;
      end
      if (sync_live) begin
        if (buf_full_q) begin
          word_d     = buf_q;
          buf_full_d = 1'b0;
        end else begin
          underflow_d = 1'b1;
        end
      end
    end
  end

  // Outputs are computed from next state so a pulse is visible on pat_o one cycle later.
  assign in_win  = (cfg_begin_i <= wfg_pat_subcycle_cnt_i) && (wfg_pat_subcycle_cnt_i <= cfg_end_i);
  assign run_win = (state_d == ST_RUNNING) && in_win;
  assign drive   = (state_d != ST_DISABLED);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_DISABLED;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      word_q      <= '0;
      underflow_q <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      word_q      <= word_d;
      underflow_q <= underflow_d;
      active_q    <= (state_d == ST_RUNNING);
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    wfg_drive_pat_channel u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush_i    (!en_i),
      .sync_i     (sync_live),
      .subcycle_i (wfg_pat_subcycle_i),
      .mode_i     (cfg_mode_i[MODE_W*i +: MODE_W]),
      .data_i     (word_d[i]),
      .drive_i    (drive),
      .run_win_i  (run_win),
      .idle_i     (cfg_idle_i[i]),
      .pat_o      (pat_o[i])
    );
  end

  assign active_o    = active_q;
  assign underflow_o = underflow_q;

`ifdef WFG_DRIVE_PAT_STATUS_EN
  logic [15:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if (!en_i) begin
      ucnt_d = '0;
    end else if (underflow_evt && (ucnt_q != 16'hFFFF)) begin
      ucnt_d = ucnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ucnt_q <= '0;
    else        ucnt_q <= ucnt_d;
  end

  assign underflow_cnt_o = ucnt_q;
`else
  logic unused_evt;
  assign unused_evt = underflow_evt;
`endif

endmodule
